// File: rtl/switch_input_port.sv
// switch_input_port: requester-side input port of a 4x4 switch.
//
// Buffers upstream words in a small FIFO and requests the arbiter while it
// holds at least one word and at least one downstream credit. Each accepted
// grant (grant && request) pops one word, which appears on out_data with a
// one-cycle out_valid strobe in the following cycle, and consumes one credit.
// credit_return pulses give credits back, saturating at CREDITS.
//
// Optional feature macro: SWITCH_PORT_ERR_EN
//   defined   -> protocol_error is a sticky flag that sets on a grant seen while
//                request is low, or on a credit_return while credits are full.
//   undefined -> protocol_error is tied to 0 and no detection logic is built.
//
// Parameters:
//   DATA_WIDTH  word width
//   DEPTH       FIFO entries (power of two, >= 2)
//   CREDITS     initial and maximum downstream credits (>= 1)
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  upstream push interface
//   request/grant           arbiter handshake for this input index
//   out_valid/out_data      registered transfer toward the crossbar
//   credit_return           downstream freed one slot (single-cycle pulse)
//   credit_count            current credits
//   occupancy               FIFO fill level
//   protocol_error          sticky error flag (see macro above)

module switch_input_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         request,
  input  logic                         grant,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         credit_return,
  output logic [$clog2(CREDITS+1)-1:0] credit_count,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         protocol_error
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [CW-1:0] CredMax = CW'(CREDITS);
  localparam logic [OW-1:0] OccMax  = OW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic push;
  logic pop;

  // Handshake outputs depend on registered state only.
  assign in_ready = (occ_q != OccMax);
  assign request  = (occ_q != '0) && (cred_q != '0);

  assign push = in_valid && in_ready;
  assign pop  = grant && request;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (push && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OW'(1);
    end
  end

  // A pop and a return in the same cycle cancel; a lone return saturates.
  always_comb begin
    cred_d = cred_q;
    if (pop && !credit_return) begin
      cred_d = cred_q - CW'(1);
    end else if (credit_return && !pop && (cred_q != CredMax)) begin
      cred_d = cred_q + CW'(1);
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    if (pop) begin
      out_data_d = mem_q[head_q];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      cred_q      <= CredMax;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      cred_q      <= cred_d;
      out_valid_q <= pop;
      out_data_q  <= out_data_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q] <= in_data;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign credit_count = cred_q;
  assign occupancy    = occ_q;

`ifdef SWITCH_PORT_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (grant && !request) || (credit_return && (cred_q == CredMax));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_error = err_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port (DATA_WIDTH=32, DEPTH=4, CREDITS=4).
// A queue-based reference model is compared against the DUT on every falling
// edge; directed sequences add hand-computed literal expectations.

module tb_switch_input_port;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 4;
`ifdef SWITCH_PORT_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          request;
  logic          grant;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          credit_return;
  logic [2:0]    credit_count;
  logic [2:0]    occupancy;
  logic          protocol_error;

  switch_input_port #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CREDITS   (CREDITS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .request       (request),
    .grant         (grant),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .credit_return (credit_return),
    .credit_count  (credit_count),
    .occupancy     (occupancy),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, credits as an integer.
  logic [DW-1:0] m_q[$];
  int            m_cred = CREDITS;
  bit            m_ov   = 1'b0;
  logic [DW-1:0] m_od   = '0;
  bit            m_err  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_cred = CREDITS;
      m_ov   = 1'b0;
      m_od   = '0;
      m_err  = 1'b0;
    end else begin
      bit req;
      bit acc;
      bit psh;
      req = (m_q.size() != 0) && (m_cred != 0);
      acc = grant && req;
      psh = in_valid && (m_q.size() < DEPTH);
      if (ErrEn && ((grant && !req) || (credit_return && m_cred == CREDITS))) m_err = 1'b1;
      m_ov = acc;
      if (acc) m_od = m_q.pop_front();
      if (psh) m_q.push_back(in_data);
      m_cred = m_cred - int'(acc) + int'(credit_return);
      if (m_cred > CREDITS) m_cred = CREDITS;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
      chk("cmp request", 64'(request), 64'((m_q.size() != 0) && (m_cred != 0)));
      chk("cmp occupancy", 64'(occupancy), 64'(m_q.size()));
      chk("cmp credit_count", 64'(credit_count), 64'(m_cred));
      chk("cmp out_valid", 64'(out_valid), 64'(m_ov));
      chk("cmp out_data", 64'(out_data), 64'(m_od));
      chk("cmp protocol_error", 64'(protocol_error), 64'(m_err));
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic g, input logic r);
    in_valid      = v;
    in_data       = d;
    grant         = g;
    credit_return = r;
    @(negedge clock);
  endtask

  logic [DW-1:0] words [4];
  int pushed;
  int xfers;

  initial begin
    words[0] = 32'h1111_0000;
    words[1] = 32'h2222_0001;
    words[2] = 32'h3333_0002;
    words[3] = 32'h4444_0003;
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    grant         = 1'b0;
    credit_return = 1'b0;
    repeat (3) @(negedge clock);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    // Reset values.
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst request", 64'(request), 64'd0);
    chk("rst credit", 64'(credit_count), 64'd4);
    chk("rst occupancy", 64'(occupancy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);

    // Single word, grant held high: 2-cycle latency.
    step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    chk("lat request", 64'(request), 64'd1);
    chk("lat occupancy", 64'(occupancy), 64'd1);
    chk("lat no early valid", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lat out_valid", 64'(out_valid), 64'd1);
    chk("lat out_data", 64'(out_data), 64'hA5A5_0001);
    chk("lat credit", 64'(credit_count), 64'd3);
    chk("lat occupancy0", 64'(occupancy), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("hold out_valid", 64'(out_valid), 64'd0);
    chk("hold out_data", 64'(out_data), 64'hA5A5_0001);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ret credit", 64'(credit_count), 64'd4);

    // Fill with grant low, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    chk("full in_ready", 64'(in_ready), 64'd0);
    chk("full occupancy", 64'(occupancy), 64'd4);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("full no push", 64'(occupancy), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain valid", 64'(out_valid), 64'd1);
      chk("drain order", 64'(out_data), 64'(words[i]));
    end
    chk("drain in_ready", 64'(in_ready), 64'd1);
    chk("drain credit", 64'(credit_count), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("refill credit", 64'(credit_count), 64'd4);

    // Credit exhaustion: six words, grant always high, no returns.
    pushed = 0;
    xfers  = 0;
    for (int i = 0; i < 14; i++) begin
      logic v;
      v = (pushed < 6) && (m_q.size() < DEPTH);
      if (v) pushed++;
      step(v, 32'hC000_0000 + 32'(pushed), 1'b1, 1'b0);
      if (out_valid) xfers++;
    end
    chk("exh transfers", 64'(xfers), 64'd4);
    chk("exh request", 64'(request), 64'd0);
    chk("exh occupancy", 64'(occupancy), 64'd2);
    xfers = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    if (out_valid) xfers++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (out_valid) xfers++;
    end
    chk("exh one more", 64'(xfers), 64'd1);
    chk("exh occupancy1", 64'(occupancy), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Grant with credit_return together at count 2, then saturation.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pre credit2", 64'(credit_count), 64'd2);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("cancel credit", 64'(credit_count), 64'd2);
    chk("cancel valid", 64'(out_valid), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("sat credit", 64'(credit_count), 64'd4);
    chk("sat error", 64'(protocol_error), 64'(ErrEn));

    // Drain the last word, then grant while empty.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("empty no valid", 64'(out_valid), 64'd0);
    chk("empty credit", 64'(credit_count), 64'd4);
    chk("empty error", 64'(protocol_error), 64'(ErrEn));

    // Asynchronous reset mid-stream, with a transfer in flight.
    step(1'b1, 32'h7777_0001, 1'b1, 1'b0);
    step(1'b1, 32'h7777_0002, 1'b1, 1'b0);
    step(1'b1, 32'h7777_0003, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst occupancy", 64'(occupancy), 64'd0);
    chk("arst credit", 64'(credit_count), 64'd4);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst request", 64'(request), 64'd0);
    chk("arst out_data", 64'(out_data), 64'd0);
    chk("arst error", 64'(protocol_error), 64'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Mixed traffic against the model.
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
